memoria_dados_pipe: RTL and testbench
=====================================

# memoria_dados_pipe

Parametrised, pipelined successor of the data memory: a single-port synchronous word RAM with valid/ready request handshake, per-byte write enables, configurable read latency and a small output queue with consumer backpressure. It sits between the processor's MEM stage (or a load/store unit) and writeback. It replaces the single-cycle memRead/memWrite memory when a multi-cycle or stallable memory path is needed.

## Interface
- LARGURA_DADO, 32, data width in bits; multiple of 8
- PROFUNDIDADE, 256, number of words; power of two
- LATENCIA, 2, read latency in cycles from accept to data; 1..4
- PROF_FILA, 4, output queue depth; must be ≥ LATENCIA
- clock  in  1  single clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- req_valido  in  1  request present
- req_pronto  out  1  request can be accepted this cycle
- memRead  in  1  request is a read
- memWrite  in  1  request is a write
- endereco  in  32  byte address
- dadoEscrita  in  LARGURA_DADO  write data
- byteEn  in  LARGURA_DADO/8  byte-lane write enables
- dadoLido  out  LARGURA_DADO  read data, head of output queue
- leituraValida  out  1  dadoLido valid
- dadoAceito  in  1  consumer takes head of queue
- erroDesalinhado  out  1  head entry came from a misaligned read

## Operation
- Accept = req_valido & req_pronto & (memRead | memWrite); nothing happens otherwise.
- Word index = endereco[log2(PROFUNDIDADE)+k-1 : k], where k = log2(LARGURA_DADO/8). Upper bits are ignored, so addresses alias modulo the array size.
- Misaligned request: endereco[k-1:0] ≠ 0.
  - Misaligned write is dropped with no array change.
  - Misaligned read still produces a queue entry: dadoLido = 0, erroDesalinhado = 1.
- Write: commits on the accept edge, only in lanes with byteEn set. byteEn = 0 is a legal no-op.
- Read: the array is read at accept. The result travels a LATENCIA-deep valid/data pipeline, then enters the output queue.
- memRead & memWrite together: write-first. The write commits, and the read returns the post-write word.
- Credit counter `ocupacao` = reads in pipeline + entries in queue.
  - req_pronto = (ocupacao < PROF_FILA). This also gates writes.
  - ocupacao increments on a read accept and decrements on leituraValida & dadoAceito; both can happen in the same cycle (net 0).
- Output queue: FIFO, in-order. The head is held stable while leituraValida & !dadoAceito.
- Array contents are not reset.

## Timing
- Reset values: req_pronto 0, leituraValida 0, dadoLido 0, erroDesalinhado 0, ocupacao 0.
- req_pronto rises at the first clock edge after reset_n deasserts.
- Read accepted at edge N: its entry is in the queue and leituraValida=1 after edge N+LATENCIA, if the queue was empty. Back-to-back reads give one result per cycle with no bubbles.
- A write at edge N is visible to a read accepted at edge N+1.
- Full condition: with ocupacao = PROF_FILA, req_pronto = 0 in the same cycle (combinational from the registered count). It rises the cycle after a pop.
- Reset asserted mid-operation: pipeline and queue are flushed immediately, all outputs go to reset values, in-flight reads are lost, and the array keeps its contents.

## Structure
- Shared package: byte-lane count, index/offset width functions (clog2-based) and the LATENCIA/PROF_FILA range checks.
- One natural sub-module: `fila_saida`, a parametrised synchronous FIFO of {erro, dado} with push/pop/full/empty. The credit counter stays in the top level.

## Test plan
- Write 0xDEADBEEF to 0x0 with byteEn=1111, then read 0x0 → leituraValida high LATENCIA cycles after accept, dadoLido = 0xDEADBEEF, erroDesalinhado = 0.
- Write 0x11223344 with byteEn=0101 over 0xDEADBEEF, then read → dadoLido = 0xDE22BE44.
- Read 0x3 → dadoLido = 0, erroDesalinhado = 1. Write to 0x6 → array unchanged.
- Hold dadoAceito = 0 and issue reads to 0x0,0x4,0x8,0xC,0x10 → req_pronto drops after the 4th accept; the 5th is held. Assert dadoAceito → results return in order, one per cycle, and req_pronto reasserts.
- memRead = memWrite = 1 to 0x8 with data 0x5A5A5A5A → the read returns 0x5A5A5A5A.
- Assert reset_n low with 3 reads in flight → leituraValida = 0 immediately and no stale results after release. A later read of 0x0 still returns the pre-reset array value.

Source files
------------

// File: rtl/memoria_dados_pipe_pkg.sv
// Shared sizing helpers and parameter range checks for the pipelined data memory.
package memoria_dados_pipe_pkg;

    localparam int LARGURA_END = 32;

    function automatic int nLanes(input int largura);
        return largura / 8;
    endfunction

    function automatic int larguraIdx(input int prof);
        return (prof > 1) ? $clog2(prof) : 1;
    endfunction

    function automatic int larguraOff(input int largura);
        return $clog2(largura / 8);
    endfunction

    function automatic bit latenciaOk(input int lat);
        return (lat >= 1) && (lat <= 4);
    endfunction

    function automatic bit filaOk(input int profFila, input int lat);
        return profFila >= lat;
    endfunction

endpackage

// File: rtl/memoria_dados_pipe_fila_saida.sv
// In-order output queue of {erro, dado}; head reads as zero while empty.
module fila_saida #(
    parameter int LARGURA = 33,
    parameter int PROF    = 4
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               push,
    input  logic [LARGURA-1:0] entrada,
    input  logic               pop,
    output logic [LARGURA-1:0] cabeca,
    output logic               cheia,
    output logic               vazia
);
    localparam int PW = (PROF > 1) ? $clog2(PROF) : 1;
    localparam int CW = $clog2(PROF + 1);

    logic [LARGURA-1:0] buffer [PROF];
    logic [PW-1:0]      ptrEsc, ptrLei;
    logic [CW-1:0]      contagem;
    logic               pushOk, popOk;

    function automatic logic [PW-1:0] proximo(input logic [PW-1:0] p);
        return (p == PW'(PROF - 1)) ? '0 : p + 1'b1;
    endfunction

    assign vazia  = (contagem == '0);
    assign cheia  = (contagem == CW'(PROF));
    assign popOk  = pop && !vazia;
    assign pushOk = push && (!cheia || popOk);
    assign cabeca = vazia ? '0 : buffer[ptrLei];

    // storage carries no reset; only pointers and count define validity
    always_ff @(posedge clock) begin
        if (pushOk) buffer[ptrEsc] <= entrada;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ptrEsc   <= '0;
            ptrLei   <= '0;
            contagem <= '0;
        end else begin
            if (pushOk) ptrEsc <= proximo(ptrEsc);
            if (popOk)  ptrLei <= proximo(ptrLei);
            case ({pushOk, popOk})
                2'b10:   contagem <= contagem + 1'b1;
                2'b01:   contagem <= contagem - 1'b1;
                default: contagem <= contagem;
            endcase
        end
    end

endmodule

// File: rtl/memoria_dados_pipe.sv
// Single-port word RAM with valid/ready requests, byte enables, fixed read
// latency and a credit-controlled output queue.
module memoria_dados_pipe
    import memoria_dados_pipe_pkg::*;
#(
    parameter int LARGURA_DADO = 32,
    parameter int PROFUNDIDADE = 256,
    parameter int LATENCIA     = 2,
    parameter int PROF_FILA    = 4
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      req_valido,
    output logic                      req_pronto,
    input  logic                      memRead,
    input  logic                      memWrite,
    input  logic [LARGURA_END-1:0]    endereco,
    input  logic [LARGURA_DADO-1:0]   dadoEscrita,
    input  logic [LARGURA_DADO/8-1:0] byteEn,
    output logic [LARGURA_DADO-1:0]   dadoLido,
    output logic                      leituraValida,
    input  logic                      dadoAceito,
    output logic                      erroDesalinhado
);
    localparam int NB = nLanes(LARGURA_DADO);
    localparam int IW = larguraIdx(PROFUNDIDADE);
    localparam int OW = larguraOff(LARGURA_DADO);
    localparam int CW = $clog2(PROF_FILA + 1);

    if (!latenciaOk(LATENCIA)) begin : gLatInvalida
        $error("LATENCIA must be in 1..4");
    end
    if (!filaOk(PROF_FILA, LATENCIA)) begin : gFilaInvalida
        $error("PROF_FILA must be >= LATENCIA");
    end
    if ((LARGURA_DADO % 8) != 0) begin : gLarguraInvalida
        $error("LARGURA_DADO must be a multiple of 8");
    end

    logic [LARGURA_DADO-1:0] mem [PROFUNDIDADE];

    logic                    ativo;
    logic [CW-1:0]           ocupacao;
    logic                    aceita, aceitaLeit, escreve, desalinhado, popFila;
    logic [IW-1:0]           indice;
    logic [LARGURA_DADO-1:0] palavraAtual, palavraMesclada, dadoLeitura;
    logic [LATENCIA:1]                   vldPipe;
    logic [LATENCIA:1][LARGURA_DADO:0]   dadoPipe;
    logic [LARGURA_DADO:0]   cabeca;
    logic                    filaCheia, filaVazia;

    assign indice      = IW'(endereco >> OW);
    assign desalinhado = (endereco & ((32'd1 << OW) - 32'd1)) != 32'd0;

    // ativo keeps req_pronto low until the first edge after reset release
    assign req_pronto = ativo && (ocupacao < CW'(PROF_FILA));
    assign aceita     = req_valido && req_pronto && (memRead || memWrite);
    assign aceitaLeit = aceita && memRead;
    assign escreve    = aceita && memWrite && !desalinhado;

    assign palavraAtual = mem[indice];

    // merged word doubles as the write-first read result
    always_comb begin
        palavraMesclada = palavraAtual;
        for (int b = 0; b < NB; b++) begin
            if (escreve && byteEn[b]) palavraMesclada[b*8 +: 8] = dadoEscrita[b*8 +: 8];
        end
    end

    assign dadoLeitura = desalinhado ? '0 : palavraMesclada;

    always_ff @(posedge clock) begin
        if (escreve) mem[indice] <= palavraMesclada;
    end

    always_ff @(posedge clock) begin
        dadoPipe[1] <= {desalinhado, dadoLeitura};
        for (int s = 2; s <= LATENCIA; s++) dadoPipe[s] <= dadoPipe[s-1];
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            vldPipe <= '0;
        end else begin
            vldPipe[1] <= aceitaLeit;
            for (int s = 2; s <= LATENCIA; s++) vldPipe[s] <= vldPipe[s-1];
        end
    end

    assign popFila = leituraValida && dadoAceito;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ativo    <= 1'b0;
            ocupacao <= '0;
        end else begin
            ativo <= 1'b1;
            case ({aceitaLeit, popFila})
                2'b10:   ocupacao <= ocupacao + 1'b1;
                2'b01:   ocupacao <= ocupacao - 1'b1;
                default: ocupacao <= ocupacao;
            endcase
        end
    end

    fila_saida #(
        .LARGURA (LARGURA_DADO + 1),
        .PROF    (PROF_FILA)
    ) uFila (
        .clock   (clock),
        .reset_n (reset_n),
        .push    (vldPipe[LATENCIA]),
        .entrada (dadoPipe[LATENCIA]),
        .pop     (popFila),
        .cabeca  (cabeca),
        .cheia   (filaCheia),
        .vazia   (filaVazia)
    );

    assign leituraValida   = !filaVazia;
    assign erroDesalinhado = cabeca[LARGURA_DADO];
    assign dadoLido        = cabeca[LARGURA_DADO-1:0];

    // credits guarantee a push never lands on a full queue without a pop
    aPushSemEspaco: assert property (@(posedge clock) disable iff (!reset_n)
        !(filaCheia && vldPipe[LATENCIA] && !popFila));

endmodule

// File: tb/tb_memoria_dados_pipe.sv
// Directed bench for memoria_dados_pipe with LATENCIA=2, PROF_FILA=4.
module tb_memoria_dados_pipe;
    localparam int LAT = 2;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        req_valido = 1'b0;
    logic        req_pronto;
    logic        memRead = 1'b0;
    logic        memWrite = 1'b0;
    logic [31:0] endereco = '0;
    logic [31:0] dadoEscrita = '0;
    logic [3:0]  byteEn = '0;
    logic [31:0] dadoLido;
    logic        leituraValida;
    logic        dadoAceito = 1'b0;
    logic        erroDesalinhado;

    int passados = 0;
    int total    = 0;

    always #5 clock = ~clock;

    memoria_dados_pipe #(
        .LARGURA_DADO (32),
        .PROFUNDIDADE (256),
        .LATENCIA     (LAT),
        .PROF_FILA    (4)
    ) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .req_valido      (req_valido),
        .req_pronto      (req_pronto),
        .memRead         (memRead),
        .memWrite        (memWrite),
        .endereco        (endereco),
        .dadoEscrita     (dadoEscrita),
        .byteEn          (byteEn),
        .dadoLido        (dadoLido),
        .leituraValida   (leituraValida),
        .dadoAceito      (dadoAceito),
        .erroDesalinhado (erroDesalinhado)
    );

    // Issue one request; returns 1 ns after its accept edge.
    task automatic doReq(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [31:0] dado, input logic [3:0] be);
        int espera = 0;
        memRead = rd; memWrite = wr; endereco = addr; dadoEscrita = dado; byteEn = be;
        req_valido = 1'b1;
        while (!req_pronto && espera < 50) begin
            @(posedge clock); #1;
            espera++;
        end
        total++;
        if (req_pronto !== 1'b1)
            $display("FAIL req_timeout: req_pronto=%b required 1 at addr %h", req_pronto, addr);
        else passados++;
        @(posedge clock); #1;
        req_valido = 1'b0; memRead = 1'b0; memWrite = 1'b0;
    endtask

    task automatic esperaValida();
        int n = 0;
        while (!leituraValida && n < 20) begin
            @(posedge clock); #1;
            n++;
        end
    endtask

    task automatic popar();
        dadoAceito = 1'b1;
        @(posedge clock); #1;
        dadoAceito = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clock);
        #1;
        total++; if (req_pronto !== 1'b0) $display("FAIL reset_pronto: got %b required 0", req_pronto); else passados++;
        total++; if (leituraValida !== 1'b0) $display("FAIL reset_valida: got %b required 0", leituraValida); else passados++;
        total++; if (dadoLido !== 32'h0) $display("FAIL reset_dado: got %h required 0", dadoLido); else passados++;
        total++; if (erroDesalinhado !== 1'b0) $display("FAIL reset_erro: got %b required 0", erroDesalinhado); else passados++;
        reset_n = 1'b1;
        #1;
        total++; if (req_pronto !== 1'b0) $display("FAIL pronto_antes_borda: got %b required 0", req_pronto); else passados++;
        @(posedge clock); #1;
        total++; if (req_pronto !== 1'b1) $display("FAIL pronto_apos_borda: got %b required 1", req_pronto); else passados++;
    endtask

    task automatic test_write_read();
        doReq(1'b0, 1'b1, 32'h0, 32'hDEADBEEF, 4'b1111);
        doReq(1'b1, 1'b0, 32'h0, 32'h0, 4'b0000);
        for (int c = 0; c < LAT; c++) begin
            total++; if (leituraValida !== 1'b0) $display("FAIL latencia_cedo: cycle %0d valida=%b required 0", c, leituraValida); else passados++;
            @(posedge clock); #1;
        end
        total++; if (leituraValida !== 1'b1) $display("FAIL latencia_valida: got %b required 1", leituraValida); else passados++;
        total++; if (dadoLido !== 32'hDEADBEEF) $display("FAIL wr_rd_dado: got %h required deadbeef", dadoLido); else passados++;
        total++; if (erroDesalinhado !== 1'b0) $display("FAIL wr_rd_erro: got %b required 0", erroDesalinhado); else passados++;
        popar();
        total++; if (leituraValida !== 1'b0) $display("FAIL wr_rd_vazio: got %b required 0", leituraValida); else passados++;
    endtask

    task automatic test_byte_enable();
        doReq(1'b0, 1'b1, 32'h0, 32'h11223344, 4'b0101);
        doReq(1'b1, 1'b0, 32'h0, 32'h0, 4'b0000);
        esperaValida();
        total++; if (dadoLido !== 32'hDE22BE44) $display("FAIL byteen_0101: got %h required de22be44", dadoLido); else passados++;
        popar();
        doReq(1'b0, 1'b1, 32'h0, 32'h0, 4'b0000);
        doReq(1'b1, 1'b0, 32'h0, 32'h0, 4'b0000);
        esperaValida();
        total++; if (dadoLido !== 32'hDE22BE44) $display("FAIL byteen_zero: got %h required de22be44", dadoLido); else passados++;
        popar();
    endtask

    task automatic test_misaligned();
        doReq(1'b1, 1'b0, 32'h3, 32'h0, 4'b0000);
        esperaValida();
        total++; if (leituraValida !== 1'b1) $display("FAIL desal_valida: got %b required 1", leituraValida); else passados++;
        total++; if (dadoLido !== 32'h0) $display("FAIL desal_dado: got %h required 0", dadoLido); else passados++;
        total++; if (erroDesalinhado !== 1'b1) $display("FAIL desal_erro: got %b required 1", erroDesalinhado); else passados++;
        popar();
        doReq(1'b0, 1'b1, 32'h4, 32'hCAFEF00D, 4'b1111);
        doReq(1'b0, 1'b1, 32'h6, 32'hFFFFFFFF, 4'b1111);
        doReq(1'b1, 1'b0, 32'h4, 32'h0, 4'b0000);
        esperaValida();
        total++; if (dadoLido !== 32'hCAFEF00D) $display("FAIL desal_escrita: got %h required cafef00d", dadoLido); else passados++;
        total++; if (erroDesalinhado !== 1'b0) $display("FAIL desal_escrita_erro: got %b required 0", erroDesalinhado); else passados++;
        popar();
        // 0x400 is word 256, which aliases to word 0
        doReq(1'b1, 1'b0, 32'h400, 32'h0, 4'b0000);
        esperaValida();
        total++; if (dadoLido !== 32'hDE22BE44) $display("FAIL alias: got %h required de22be44", dadoLido); else passados++;
        popar();
    endtask

    task automatic test_back_to_back();
        logic [31:0] esperado [5];
        logic acc;
        esperado[0] = 32'hDE22BE44; esperado[1] = 32'hCAFEF00D; esperado[2] = 32'h88888888;
        esperado[3] = 32'hCCCCCCCC; esperado[4] = 32'h10101010;
        doReq(1'b0, 1'b1, 32'h8,  32'h88888888, 4'b1111);
        doReq(1'b0, 1'b1, 32'hC,  32'hCCCCCCCC, 4'b1111);
        doReq(1'b0, 1'b1, 32'h10, 32'h10101010, 4'b1111);
        dadoAceito = 1'b0; memWrite = 1'b0; memRead = 1'b1; req_valido = 1'b1;
        for (int i = 0; i < 4; i++) begin
            endereco = 32'(i * 4);
            @(posedge clock); #1;
        end
        endereco = 32'h10;
        total++; if (req_pronto !== 1'b0) $display("FAIL cheio_pronto: got %b required 0", req_pronto); else passados++;
        repeat (3) begin @(posedge clock); #1; end
        total++; if (req_pronto !== 1'b0) $display("FAIL cheio_retido: got %b required 0", req_pronto); else passados++;
        total++; if (dadoLido !== esperado[0]) $display("FAIL cabeca_estavel: got %h required %h", dadoLido, esperado[0]); else passados++;
        dadoAceito = 1'b1;
        for (int k = 0; k < 5; k++) begin
            total++;
            if (leituraValida !== 1'b1 || dadoLido !== esperado[k])
                $display("FAIL ordem_%0d: valida=%b dado=%h required 1 %h", k, leituraValida, dadoLido, esperado[k]);
            else passados++;
            acc = req_valido && req_pronto;
            @(posedge clock); #1;
            if (acc) begin req_valido = 1'b0; memRead = 1'b0; end
            if (k == 0) begin
                total++; if (req_pronto !== 1'b1) $display("FAIL pronto_apos_pop: got %b required 1", req_pronto); else passados++;
            end
        end
        dadoAceito = 1'b0;
        total++; if (leituraValida !== 1'b0) $display("FAIL fila_drenada: got %b required 0", leituraValida); else passados++;
    endtask

    task automatic test_write_first();
        doReq(1'b1, 1'b1, 32'h8, 32'h5A5A5A5A, 4'b1111);
        esperaValida();
        total++; if (dadoLido !== 32'h5A5A5A5A) $display("FAIL write_first: got %h required 5a5a5a5a", dadoLido); else passados++;
        popar();
        doReq(1'b1, 1'b0, 32'h8, 32'h0, 4'b0000);
        esperaValida();
        total++; if (dadoLido !== 32'h5A5A5A5A) $display("FAIL write_first_persist: got %h required 5a5a5a5a", dadoLido); else passados++;
        popar();
    endtask

    task automatic test_reset_midflight();
        logic viuValida = 1'b0;
        memRead = 1'b1; memWrite = 1'b0; req_valido = 1'b1;
        endereco = 32'h0; @(posedge clock); #1;
        endereco = 32'h4; @(posedge clock); #1;
        endereco = 32'h8; @(posedge clock); #1;
        req_valido = 1'b0; memRead = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        total++; if (leituraValida !== 1'b0) $display("FAIL rst_meio_valida: got %b required 0", leituraValida); else passados++;
        total++; if (req_pronto !== 1'b0) $display("FAIL rst_meio_pronto: got %b required 0", req_pronto); else passados++;
        total++; if (dadoLido !== 32'h0) $display("FAIL rst_meio_dado: got %h required 0", dadoLido); else passados++;
        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;
        repeat (6) begin
            @(posedge clock); #1;
            if (leituraValida) viuValida = 1'b1;
        end
        total++; if (viuValida !== 1'b0) $display("FAIL rst_resto: stale valida=%b required 0", viuValida); else passados++;
        doReq(1'b1, 1'b0, 32'h0, 32'h0, 4'b0000);
        esperaValida();
        total++; if (dadoLido !== 32'hDE22BE44) $display("FAIL rst_array: got %h required de22be44", dadoLido); else passados++;
        popar();
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_byte_enable();
        test_misaligned();
        test_back_to_back();
        test_write_first();
        test_reset_midflight();
        $display("%0d/%0d checks passed", passados, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d done", passados, total);
        $fatal(1, "watchdog");
    end

endmodule
